// File: rtl/control_flujo_datos_pkg.sv
// Shared types for the I/V estimator data-flow sequencer: FSM state encoding
// and sizing of the inter-iteration gap counter.
package control_flujo_datos_pkg;

    typedef enum logic [2:0] {
        ST_RST       = 3'd0,
        ST_LN_START  = 3'd1,
        ST_LN_WAIT   = 3'd2,
        ST_EST_START = 3'd3,
        ST_EST_WAIT  = 3'd4,
        ST_DLN_START = 3'd5,
        ST_DLN_WAIT  = 3'd6,
        ST_GAP_WAIT  = 3'd7
    } state_t;

    // Width of a down-counter able to hold GAP; never narrower than one bit.
    function automatic int gap_cnt_w(input int gap);
        int w;
        w = $clog2(gap + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/control_flujo_datos_ack_join.sv
// Two-input sticky acknowledge collector. both_done also sees same-cycle
// pulses so the join completes on the edge where the last ack arrives.
module control_flujo_datos_ack_join (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_a,
    input  logic i_b,
    output logic o_both_done
);

    logic r_a_seen;
    logic r_b_seen;
    logic w_a_seen;
    logic w_b_seen;

    assign w_a_seen = r_a_seen | (i_en & i_a);
    assign w_b_seen = r_b_seen | (i_en & i_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_seen <= 1'b0;
            r_b_seen <= 1'b0;
        end else if (i_clr) begin
            r_a_seen <= 1'b0;
            r_b_seen <= 1'b0;
        end else if (i_en) begin
            r_a_seen <= w_a_seen;
            r_b_seen <= w_b_seen;
        end
    end

    assign o_both_done = i_en & w_a_seen & w_b_seen;

endmodule

// File: rtl/control_flujo_datos.sv
// Data-flow sequencer: linearizer pair -> estimator -> de-linearizer pair,
// repeated forever with optional idle gap. Orders stages only, holds no data.
module control_flujo_datos
    import control_flujo_datos_pkg::*;
#(
    parameter int GAP = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic ack_i,
    input  logic ack_v,
    input  logic ack_e,
    input  logic ack_d1,
    input  logic ack_d2,
    output logic start_i,
    output logic start_v,
    output logic start_e,
    output logic start_d1,
    output logic start_d2
);

    localparam int GAP_W = gap_cnt_w(GAP);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP > 0) ? (GAP - 1) : 0);

    state_t           r_state;
    state_t           w_next;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_start_ln;
    logic             r_start_est;
    logic             r_start_dln;

    logic w_ln_clr;
    logic w_ln_en;
    logic w_ln_done;
    logic w_dln_clr;
    logic w_dln_en;
    logic w_dln_done;

    assign w_ln_clr  = (r_state == ST_LN_START);
    assign w_ln_en   = (r_state == ST_LN_WAIT);
    assign w_dln_clr = (r_state == ST_DLN_START);
    assign w_dln_en  = (r_state == ST_DLN_WAIT);

    control_flujo_datos_ack_join u_join_ln (
        .clk         (clk),
        .rst_n       (reset),
        .i_clr       (w_ln_clr),
        .i_en        (w_ln_en),
        .i_a         (ack_i),
        .i_b         (ack_v),
        .o_both_done (w_ln_done)
    );

    control_flujo_datos_ack_join u_join_dln (
        .clk         (clk),
        .rst_n       (reset),
        .i_clr       (w_dln_clr),
        .i_en        (w_dln_en),
        .i_a         (ack_d1),
        .i_b         (ack_d2),
        .o_both_done (w_dln_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RST;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_RST:       w_next = ST_LN_START;
            ST_LN_START:  w_next = ST_LN_WAIT;
            ST_LN_WAIT:   if (w_ln_done) w_next = ST_EST_START;
            ST_EST_START: w_next = ST_EST_WAIT;
            ST_EST_WAIT:  if (ack_e) w_next = ST_DLN_START;
            ST_DLN_START: w_next = ST_DLN_WAIT;
            ST_DLN_WAIT: begin
                if (w_dln_done) begin
                    w_next = (GAP > 0) ? ST_GAP_WAIT : ST_LN_START;
                end
            end
            ST_GAP_WAIT:  if (r_gap_cnt == '0) w_next = ST_LN_START;
            default:      w_next = ST_RST;
        endcase
    end

    // Loaded on the join edge so GAP_WAIT lasts exactly GAP cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gap_cnt <= '0;
        end else if (w_dln_done) begin
            r_gap_cnt <= GAP_LOAD;
        end else if ((r_state == ST_GAP_WAIT) && (r_gap_cnt != '0)) begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
        end
    end

    // Start strobes come straight from flops decoded off the next state,
    // so they are glitch-free and track the state register cycle for cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_start_ln  <= 1'b0;
            r_start_est <= 1'b0;
            r_start_dln <= 1'b0;
        end else begin
            r_start_ln  <= (w_next == ST_LN_START);
            r_start_est <= (w_next == ST_EST_START);
            r_start_dln <= (w_next == ST_DLN_START);
        end
    end

    assign start_i  = r_start_ln;
    assign start_v  = r_start_ln;
    assign start_e  = r_start_est;
    assign start_d1 = r_start_dln;
    assign start_d2 = r_start_dln;

endmodule

// File: tb/tb_control_flujo_datos.sv
// Scoreboard bench for control_flujo_datos: one GAP=0 and one GAP=3 instance,
// expected start pulses (kind and cycle) queued as acks are driven.
module tb_control_flujo_datos;

    localparam logic [4:0] LN  = 5'b11000;
    localparam logic [4:0] EST = 5'b00100;
    localparam logic [4:0] DLN = 5'b00011;
    localparam logic [4:0] A_I  = 5'b10000;
    localparam logic [4:0] A_V  = 5'b01000;
    localparam logic [4:0] A_E  = 5'b00100;
    localparam logic [4:0] A_D1 = 5'b00010;
    localparam logic [4:0] A_D2 = 5'b00001;

    typedef struct {
        logic [4:0] st;
        int         at;
    } exp_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] a0    = '0;
    logic [4:0] a3    = '0;
    wire  [4:0] s0;
    wire  [4:0] s3;
    int         cyc    = 0;
    int         errors = 0;
    int         checks = 0;
    int         st_e;
    exp_t       q0[$];
    exp_t       q3[$];
    exp_t       e0;
    exp_t       e3;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    control_flujo_datos #(.GAP(0)) dut0 (
        .clk(clk), .reset(reset),
        .ack_i(a0[4]), .ack_v(a0[3]), .ack_e(a0[2]), .ack_d1(a0[1]), .ack_d2(a0[0]),
        .start_i(s0[4]), .start_v(s0[3]), .start_e(s0[2]), .start_d1(s0[1]), .start_d2(s0[0])
    );

    control_flujo_datos #(.GAP(3)) dut3 (
        .clk(clk), .reset(reset),
        .ack_i(a3[4]), .ack_v(a3[3]), .ack_e(a3[2]), .ack_d1(a3[1]), .ack_d2(a3[0]),
        .start_i(s3[4]), .start_v(s3[3]), .start_e(s3[2]), .start_d1(s3[1]), .start_d2(s3[0])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse0(input logic [4:0] m);
        a0 = m;
        @(posedge clk);
        #1;
        a0 = '0;
    endtask

    task automatic pulse3(input logic [4:0] m);
        a3 = m;
        @(posedge clk);
        #1;
        a3 = '0;
    endtask

    task automatic exp0(input logic [4:0] st, input int at);
        q0.push_back('{st: st, at: at});
    endtask

    task automatic exp3(input logic [4:0] st, input int at);
        q3.push_back('{st: st, at: at});
    endtask

    task automatic release_reset();
        reset = 1'b1;
        exp0(LN, cyc + 1);
        exp3(LN, cyc + 1);
    endtask

    always @(negedge clk) begin
        if (s0 !== 5'b0) begin
            if (q0.size() == 0) begin
                check("d0_unexpected_start", {27'b0, s0}, 32'h0);
            end else begin
                e0 = q0.pop_front();
                check("d0_start_kind", {27'b0, s0}, {27'b0, e0.st});
                check("d0_start_cycle", cyc, e0.at);
            end
        end
        if (s3 !== 5'b0) begin
            if (q3.size() == 0) begin
                check("d3_unexpected_start", {27'b0, s3}, 32'h0);
            end else begin
                e3 = q3.pop_front();
                check("d3_start_kind", {27'b0, s3}, {27'b0, e3.st});
                check("d3_start_cycle", cyc, e3.at);
            end
        end
    end

    initial begin
        idle(3);
        check("rst_starts_d0", {27'b0, s0}, 32'h0);
        check("rst_starts_d3", {27'b0, s3}, 32'h0);

        // Release with acks low: one LN pulse, then silence.
        release_reset();
        idle(12);

        // Split LN acks with spurious and repeated acks in between.
        pulse0(A_I);
        idle(2);
        pulse0(A_E);
        pulse0(A_D1);
        pulse0(A_I);
        idle(1);
        exp0(EST, cyc + 1);
        pulse0(A_V);
        st_e = cyc;
        // ack_e during EST_START is dropped; real one 4 cycles after start_e.
        pulse0(A_E);
        idle(3);
        check("ack_e_timing", cyc, st_e + 4);
        exp0(DLN, cyc + 1);
        pulse0(A_E);
        // ack_d1 during DLN_START is dropped, so the join needs a later d1.
        pulse0(A_D1);
        pulse0(A_D2);
        idle(1);
        exp0(LN, cyc + 1);
        pulse0(A_D1);

        // Minimum-length iteration: every join completes on its first WAIT edge.
        idle(1);
        exp0(EST, cyc + 1);
        pulse0(A_I | A_V);
        idle(1);
        exp0(DLN, cyc + 1);
        pulse0(A_E);
        idle(1);
        exp0(LN, cyc + 1);
        pulse0(A_D1 | A_D2);
        idle(1);

        // GAP=3 instance: three idle cycles after the DLN join.
        exp3(EST, cyc + 1);
        pulse3(A_I | A_V);
        idle(1);
        exp3(DLN, cyc + 1);
        pulse3(A_E);
        idle(1);
        pulse3(A_D1);
        idle(1);
        exp3(LN, cyc + 4);
        pulse3(A_D2);
        pulse3(A_I);
        idle(6);

        // Reset asserted in EST_WAIT with ack_e pending across the release.
        exp0(EST, cyc + 1);
        pulse0(A_I | A_V);
        idle(2);
        a0 = A_E;
        #1;
        reset = 1'b0;
        #1;
        check("rst_est_wait_d0", {27'b0, s0}, 32'h0);
        check("rst_est_wait_d3", {27'b0, s3}, 32'h0);
        idle(2);
        release_reset();
        idle(6);
        a0 = '0;
        idle(2);

        // Asynchronous drop of an active start pulse, no clock edge involved.
        pulse0(A_I | A_V);
        #1;
        check("est_pulse_before_rst", {27'b0, s0}, {27'b0, EST});
        reset = 1'b0;
        #1;
        check("async_drop_d0", {27'b0, s0}, 32'h0);
        idle(2);
        release_reset();
        idle(5);

        check("sb_drain_d0", q0.size(), 0);
        check("sb_drain_d3", q3.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
